// File: rtl/axi_sram_burst_slave.sv
// AXI3-style burst slave in front of a single-port synchronous SRAM.
// One transaction at a time. Bursts are FIXED or INCR, each 1..16 beats.
// Each beat is range-checked against ADDR_LIMIT.
// Optional feature: define SRAM_SLAVE_WRAP_EN to accept WRAP bursts with LEN 1/3/7/15.
// Without it, WRAP is treated like the reserved burst encoding: the burst is handshaken,
// the SRAM is not touched, and the response is SLVERR.
// Read timing: DO is expected valid at the end of the MEM_LATENCY-th strobe cycle.
module axi_sram_burst_slave #(
  parameter int          ID_WIDTH    = 8,
  parameter int          MEM_AW      = 14,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0001_FFFF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address channel
  input  logic [ID_WIDTH-1:0] AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data channel
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response channel
  output logic [ID_WIDTH-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address channel
  input  logic [ID_WIDTH-1:0] ARID,
  input  logic [31:0]         ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data channel
  output logic [ID_WIDTH-1:0] RID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  // SRAM port
  output logic                CS,
  output logic                OE,
  output logic [3:0]          WEB,
  output logic [MEM_AW-1:0]   A,
  output logic [31:0]         DI,
  input  logic [31:0]         DO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RWAIT,
    ST_RDATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
`ifdef SRAM_SLAVE_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [3:0]          len_q;
  logic [1:0]          burst_q;
  logic [3:0]          beat_cnt;
  logic [1:0]          lat_cnt;
  logic [1:0]          wresp_acc;
  logic                last_was_read;

  logic                grant_w;
  logic                grant_r;
  logic                burst_ok;
  logic                in_range;
  logic                beat_access;
  logic [1:0]          beat_resp;
  logic [31:0]         next_addr;
  logic [MEM_AW-1:0]   word_idx;
  logic                last_by_count;
  logic [1:0]          wr_final_resp;
`ifdef SRAM_SLAVE_WRAP_EN
  logic [31:0]         wrap_mask;
`endif

  // Response codes are ordered so the numerically larger one is the more severe one.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Arbitration: on a tie, serve the direction that was not served last time.
  always_comb begin
    grant_w = AWVALID && (!ARVALID || last_was_read);
    grant_r = ARVALID && (!AWVALID || !last_was_read);
  end

  assign AWREADY = ARESETn && (state == ST_IDLE) && grant_w;
  assign ARREADY = ARESETn && (state == ST_IDLE) && grant_r;
  assign WREADY  = ARESETn && (state == ST_WDATA);

  // Decode the current beat: legality, range, response, SRAM index and next address.
  always_comb begin
    burst_ok = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
    next_addr = addr_q;
`ifdef SRAM_SLAVE_WRAP_EN
    wrap_mask = {26'd0, len_q, 2'b11};
    if ((burst_q == BURST_WRAP) &&
        ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15)))
      burst_ok = 1'b1;
    if (burst_q == BURST_WRAP)
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
`endif
    if (burst_q == BURST_INCR)
      next_addr = addr_q + 32'd4;
    in_range      = (addr_q <= ADDR_LIMIT);
    beat_access   = burst_ok && in_range;
    beat_resp     = !burst_ok ? RESP_SLVERR : (!in_range ? RESP_DECERR : RESP_OKAY);
    word_idx      = addr_q[MEM_AW+1:2];
    last_by_count = (beat_cnt == len_q);
    wr_final_resp = worst(wresp_acc, beat_resp);
    if (WLAST != last_by_count)
      wr_final_resp = worst(wr_final_resp, RESP_SLVERR);
  end

  // SRAM strobes: writes happen in the same cycle as the W handshake, reads are held through RWAIT.
  always_comb begin
    CS  = 1'b0;
    OE  = 1'b0;
    WEB = 4'hF;
    A   = '0;
    DI  = '0;
    if ((state == ST_WDATA) && WVALID && beat_access) begin
      CS  = 1'b1;
      WEB = ~WSTRB;
      A   = word_idx;
      DI  = WDATA;
    end else if ((state == ST_RWAIT) && beat_access) begin
      CS = 1'b1;
      OE = 1'b1;
      A  = word_idx;
    end
  end

  // Transaction FSM with registered B and R channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= ST_IDLE;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      burst_q       <= '0;
      beat_cnt      <= '0;
      lat_cnt       <= '0;
      wresp_acc     <= RESP_OKAY;
      last_was_read <= 1'b1;
      BVALID        <= 1'b0;
      BID           <= '0;
      BRESP         <= RESP_OKAY;
      RVALID        <= 1'b0;
      RID           <= '0;
      RDATA         <= '0;
      RRESP         <= RESP_OKAY;
      RLAST         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_w) begin
            id_q          <= AWID;
            addr_q        <= AWADDR;
            len_q         <= AWLEN;
            burst_q       <= AWBURST;
            beat_cnt      <= '0;
            wresp_acc     <= RESP_OKAY;
            last_was_read <= 1'b0;
            state         <= ST_WDATA;
          end else if (grant_r) begin
            id_q          <= ARID;
            RID           <= ARID;
            addr_q        <= ARADDR;
            len_q         <= ARLEN;
            burst_q       <= ARBURST;
            beat_cnt      <= '0;
            lat_cnt       <= '0;
            last_was_read <= 1'b1;
            state         <= ST_RWAIT;
          end
        end
        ST_WDATA: begin
          if (WVALID) begin
            if (WLAST || last_by_count) begin
              BVALID <= 1'b1;
              BID    <= id_q;
              BRESP  <= wr_final_resp;
              state  <= ST_WRESP;
            end else begin
              wresp_acc <= worst(wresp_acc, beat_resp);
              addr_q    <= next_addr;
              beat_cnt  <= beat_cnt + 4'd1;
            end
          end
        end
        ST_WRESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            RVALID <= 1'b1;
            RDATA  <= beat_access ? DO : 32'd0;
            RRESP  <= beat_resp;
            RLAST  <= last_by_count;
            state  <= ST_RDATA;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ST_RDATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            if (last_by_count) begin
              state <= ST_IDLE;
            end else begin
              addr_q   <= next_addr;
              beat_cnt <= beat_cnt + 4'd1;
              lat_cnt  <= '0;
              state    <= ST_RWAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_sram_burst_slave.md
AXI_SRAM_BURST_SLAVE -- requirements
Module: axi_sram_burst_slave

Interface
REQ-001 Parameter ID_WIDTH, default 8, width of AWID/ARID/BID/RID.
REQ-002 Parameter MEM_AW, default 14, SRAM word-address width; SRAM word index = byte address [MEM_AW+1:2].
REQ-003 Parameter MEM_LATENCY, default 1, cycles from SRAM read strobe to valid DO (range 1..3).
REQ-004 Parameter ADDR_LIMIT, default 32'h0001_FFFF, highest legal byte address.
REQ-005 ACLK  in  1  clock, all logic on rising edge.
REQ-006 ARESETn  in  1  reset, asynchronous, active-low.
REQ-007 AW channel: AWID in ID_WIDTH; AWADDR in 32; AWLEN in 4; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-008 W channel: WDATA in 32; WSTRB in 4; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-009 B channel: BID out ID_WIDTH; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-010 AR channel: ARID in ID_WIDTH; ARADDR in 32; ARLEN in 4; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-011 R channel: RID out ID_WIDTH; RDATA out 32; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-012 SRAM port: CS out 1 chip select; OE out 1 read enable; WEB out 4 active-low byte write enables; A out MEM_AW; DI out 32; DO in 32.

Function
REQ-013 FSM states: IDLE, WDATA, WRESP, RWAIT, RDATA; one transaction in flight at a time.
REQ-014 IDLE: AWREADY/ARREADY asserted combinationally only for the granted request; handshake captures ID, address, LEN, BURST; next state WDATA (write) or RWAIT (read).
REQ-015 Arbitration: AWVALID and ARVALID in same IDLE cycle -> grant opposite of last granted direction; after reset, write first.
REQ-016 Burst types: FIXED (00) keeps address; INCR (01) adds 4 per beat; beats = LEN+1 (1..16).
REQ-017 Range check per beat: address > ADDR_LIMIT -> DECERR (2'b11), no SRAM access for that beat; else OKAY (2'b00).
REQ-018 WDATA: WREADY=1; on WVALID&&WREADY in-range, same cycle CS=1, WEB=~WSTRB, A=word index, DI=WDATA; WEB=4'hF otherwise.
REQ-019 Write end: WLAST beat or beat count reaching LEN+1 -> WRESP; WLAST mismatched with count -> BRESP SLVERR (2'b10).
REQ-020 BRESP = worst response of all beats (DECERR > SLVERR > OKAY); BVALID held until BREADY, then IDLE.
REQ-021 RWAIT: CS=1, OE=1, A=word index for MEM_LATENCY cycles, then DO registered into RDATA; next RDATA.
REQ-022 RDATA: RVALID=1, RID=captured ID, RLAST=1 on beat LEN; RDATA/RRESP stable while RVALID&&!RREADY.
REQ-023 RREADY handshake: last beat -> IDLE; else advance address -> RWAIT; per-beat throughput MEM_LATENCY+1 cycles.
REQ-024 Out-of-range read beat: skips SRAM, RDATA=0, RRESP=DECERR, still counted.
REQ-025 INCR address crossing 4 KB boundary continues linearly; no wrap on non-WRAP bursts.
REQ-026 Reserved AWBURST/ARBURST (11): full burst still handshaken, no SRAM access, response SLVERR.

Reset
REQ-027 ARESETn low: FSM IDLE; all VALID/READY, CS, OE = 0; WEB=4'hF; A, DI, RDATA, BRESP, RRESP, IDs = 0; arbiter last-grant = read.
REQ-028 Reset mid-burst abandons transaction immediately; no further SRAM strobes; no response issued.

Configuration
REQ-029 Macro SRAM_SLAVE_WRAP_EN defined: WRAP (10) bursts supported, LEN in {1,3,7,15}, address wraps at (LEN+1)*4-aligned boundary.
REQ-030 Macro undefined: WRAP handled as reserved per REQ-026 (SLVERR, no SRAM access).

Verification
REQ-031 Single write AWADDR=0x100, LEN=0, WSTRB=4'b0011, WDATA=0xAABBCCDD -> WEB=4'b1100, A=0x40 one cycle, BRESP=00.
REQ-032 INCR read ARADDR=0x200, LEN=3, MEM_LATENCY=2, RREADY=1 -> A=0x80..0x83, 4 beats each 3 cycles apart, RLAST on 4th only.
REQ-033 AWVALID and ARVALID together after reset -> write granted; next simultaneous pair -> read granted.
REQ-034 Write AWADDR=0x0002_0000 -> no CS, BRESP=11; read same address -> RDATA=0, RRESP=11.
REQ-035 RREADY held low 5 cycles on beat 1 -> RVALID/RDATA/RLAST stable all 5 cycles.
REQ-036 WRAP read ARADDR=0x1C, LEN=3 -> with macro A=0x7,0x4,0x5,0x6 OKAY; without macro no CS, RRESP=10 on all 4 beats.
